// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle RV32I control sequencer driving datapath selects, enables and memory handshake
// Optional feature macro CTRL_ILLEGAL_TRAP_EN: unsupported opcodes park the sequencer in TRAP until reset;
// without it they retire as no-operations after a one-cycle illegal pulse in DECODE.
module core_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_is_fetch,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [1:0]       alu_a_sel,
    output logic             alu_b_sel,
    output logic [2:0]       imm_type,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;
    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_IMM   = 2'b01;
    localparam logic [1:0] PC_ALU   = 2'b10;
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_LINK  = 2'b10;
    localparam logic [1:0] A_RS1    = 2'b00;
    localparam logic [1:0] A_PC     = 2'b01;
    localparam logic [1:0] A_ZERO   = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    logic [6:0]       opc;
    logic             unused_instr;
    logic             is_op, is_opimm, is_load, is_store, is_branch;
    logic             is_jal, is_jalr, is_lui, is_auipc, is_fence, is_system;
    logic             is_alu, is_mem, is_link, is_legal, in_body;
    logic [2:0]       imm_dec;
    logic [1:0]       alu_a_dec;
    logic             alu_b_dec;

    // Only the opcode field steers control; the rest of the word belongs to the datapath.
    assign opc          = instr[6:0];
    assign unused_instr = ^instr[31:7];

    assign is_op     = opc == OPC_OP;
    assign is_opimm  = opc == OPC_OPIMM;
    assign is_load   = opc == OPC_LOAD;
    assign is_store  = opc == OPC_STORE;
    assign is_branch = opc == OPC_BRANCH;
    assign is_jal    = opc == OPC_JAL;
    assign is_jalr   = opc == OPC_JALR;
    assign is_lui    = opc == OPC_LUI;
    assign is_auipc  = opc == OPC_AUIPC;
    assign is_fence  = opc == OPC_FENCE;
    assign is_system = opc == OPC_SYSTEM;

    // Instruction groups that share a path through the sequencer.
    assign is_alu   = is_op | is_opimm | is_lui | is_auipc;
    assign is_mem   = is_load | is_store;
    assign is_link  = is_jal | is_jalr;
    assign is_legal = is_alu | is_mem | is_branch | is_link | is_fence | is_system;

    // Immediate format and ALU operand routing per opcode; unknown opcodes fall back to I-type.
    assign imm_dec   = is_store ? IMM_S :
                       is_branch ? IMM_B :
                       (is_lui | is_auipc) ? IMM_U :
                       is_jal ? IMM_J : IMM_I;
    assign alu_a_dec = is_lui ? A_ZERO : is_auipc ? A_PC : A_RS1;
    assign alu_b_dec = ~(is_op | is_branch);

    // The immediate generator is only meaningful while an instruction is in flight past fetch.
    assign in_body  = (state_q == S_DECODE) | (state_q == S_EXEC) | (state_q == S_MEM) | (state_q == S_WB);
    assign imm_type = in_body ? imm_dec : IMM_I;
    assign state    = state_q;
    assign instret  = instret_q;

    // State register and retired-instruction counter; reset aborts any in-flight instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state and per-state control outputs; retire marks the edge leaving an instruction's last state.
    always_comb begin
        state_d      = state_q;
        retire       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = PC_PLUS4;
        reg_we       = 1'b0;
        wb_sel       = WB_ALU;
        alu_a_sel    = A_RS1;
        alu_b_sel    = 1'b0;
        illegal      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req      = 1'b1;
                mem_is_fetch = 1'b1;
                ir_we        = mem_ready;
                state_d      = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                illegal = ~is_legal;
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_d = is_legal ? S_EXEC : S_TRAP;
`else
                state_d = S_EXEC;
`endif
            end
            S_EXEC: begin
                alu_a_sel = alu_a_dec;
                alu_b_sel = alu_b_dec;
                if (is_mem) begin
                    state_d = S_MEM;
                end else if (is_alu) begin
                    state_d = S_WB;
                end else begin
                    pc_we   = 1'b1;
                    pc_sel  = is_jal ? PC_IMM :
                              is_jalr ? PC_ALU :
                              (is_branch & branch_taken) ? PC_IMM : PC_PLUS4;
                    reg_we  = is_link;
                    wb_sel  = is_link ? WB_LINK : WB_ALU;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req   = 1'b1;
                mem_we    = is_store;
                alu_a_sel = alu_a_dec;
                alu_b_sel = alu_b_dec;
                pc_we     = mem_ready & is_store;
                retire    = mem_ready & is_store;
                state_d   = ~mem_ready ? S_MEM : is_load ? S_WB : S_FETCH;
            end
            S_WB: begin
                alu_a_sel = alu_a_dec;
                alu_b_sel = alu_b_dec;
                reg_we    = 1'b1;
                wb_sel    = is_load ? WB_MEM : WB_ALU;
                pc_we     = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_d = S_IDLE;
        endcase
        instret_d = retire ? instret_q + CNT_ONE : instret_q;
    end
endmodule

// File: doc/core_ctrl.md
# core_ctrl

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback. From the opcode held in the instruction register it drives all datapath selects, the register-file, PC and IR write enables, and the memory request handshake. It also produces the 3-bit type code that configures the immediate generator, and keeps a retired-instruction counter.

## Interface
- `CNT_W`, 32: width of the retired-instruction counter.
- `clk`  in  1: core clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `instr`  in  32: current instruction register contents; only [6:0] is decoded.
- `mem_ready`  in  1: memory has completed the current request this cycle.
- `branch_taken`  in  1: branch comparison result from the ALU, valid in EXEC.
- `mem_req`  out  1: memory request, held until `mem_ready`.
- `mem_we`  out  1: store request; qualifies `mem_req`.
- `mem_is_fetch`  out  1: address mux select, 1 = PC, 0 = ALU result.
- `ir_we`  out  1: instruction register load.
- `pc_we`  out  1: PC load.
- `pc_sel`  out  2: next-PC select: 00 = pc+4, 01 = pc+imm, 10 = ALU result with bit 0 cleared.
- `reg_we`  out  1: register-file write.
- `wb_sel`  out  2: writeback source: 00 = ALU, 01 = memory data, 10 = pc+4.
- `alu_a_sel`  out  2: ALU A operand: 00 = rs1, 01 = PC, 10 = zero.
- `alu_b_sel`  out  1: ALU B operand: 0 = rs2, 1 = immediate.
- `imm_type`  out  3: immediate type code: 000 = I, 001 = S, 010 = B, 011 = U, 100 = J.
- `state`  out  3: current state, for debug.
- `illegal`  out  1: unsupported opcode detected.
- `instret`  out  CNT_W: count of retired instructions.

## Operation
- **States:** IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- **Reset:** `rst` forces IDLE, `instret`=0 and every output to 0. IDLE lasts one cycle after reset release, then moves to FETCH.
- **FETCH:**
  - Drives `mem_req`=1 and `mem_is_fetch`=1.
  - Stays in FETCH while `mem_ready`=0.
  - In the cycle where `mem_ready`=1: `ir_we`=1, next state DECODE.
- **DECODE:** one cycle, no side effects. `imm_type` is combinational from `instr[6:0]` and is valid in DECODE, EXEC, MEM and WB; it is 000 in the other states.
- **Opcode map** (imm_type / EXEC action / next state):
  - OP 0110011: I type (unused); rs1 op rs2 → WB.
  - OP-IMM 0010011: I; rs1 op imm → WB.
  - LOAD 0000011: I; address rs1+imm → MEM.
  - STORE 0100011: S; address rs1+imm → MEM.
  - BRANCH 1100011: B. In EXEC `pc_we`=1 with `pc_sel`=01 if `branch_taken`, else 00; retire → FETCH.
  - JAL 1101111: J. In EXEC `reg_we`=1, `wb_sel`=10, `pc_we`=1, `pc_sel`=01; retire → FETCH.
  - JALR 1100111: I. Same as JAL except `alu_a_sel`=00, `alu_b_sel`=1, `pc_sel`=10.
  - LUI 0110111: U; ALU A = zero, B = imm → WB.
  - AUIPC 0010111: U; ALU A = PC, B = imm → WB.
  - FENCE 0001111 and SYSTEM 1110011: no operation. In EXEC `pc_we`=1 with `pc_sel`=00; retire → FETCH.
  - Any other opcode is illegal; see Configuration.
- **MEM:**
  - Drives `mem_req`=1, `mem_is_fetch`=0, `mem_we`=1 for stores.
  - ALU selects are held from EXEC.
  - Waits for `mem_ready`. On ready, a load goes to WB; a store does `pc_we`=1 with `pc_sel`=00, retires and goes to FETCH.
- **WB:** `reg_we`=1; `wb_sel`=01 for loads, 00 otherwise; `pc_we`=1 with `pc_sel`=00; retire → FETCH.
- **Retire:** `instret` increments by 1 on the edge that leaves the final state of an instruction. It wraps modulo 2^CNT_W.

## Timing
- Cycle counts with zero-wait memory (`mem_ready` high on the first request cycle):
  - ALU, LUI, AUIPC: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch, JAL, JALR, FENCE, SYSTEM: 3 cycles.
- Each memory wait cycle adds exactly one cycle.
- All outputs are combinational from the state register and `instr[6:0]`. `instr` must be stable from DECODE until the instruction retires.
- `mem_req` never drops while waiting for `mem_ready`. `mem_ready` outside FETCH and MEM is ignored.
- In JAL/JALR EXEC, `reg_we` and `pc_we` assert in the same cycle; the datapath samples the old PC for pc+4.
- Asserting `rst` mid-instruction aborts the instruction immediately: no write and no `instret` increment after assertion.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode in DECODE moves to TRAP.
  - TRAP holds `illegal`=1 with all enables 0 until reset.
  - An illegal instruction does not count toward `instret`.
- `CTRL_ILLEGAL_TRAP_EN` undefined:
  - An illegal opcode is treated as a no-operation: EXEC with `pc_sel`=00, retire, then FETCH.
  - `illegal` pulses 1 for the DECODE cycle only.
  - TRAP is unreachable.

## Test plan
- Reset release, `mem_ready` tied to 1, instr=0x00500093 (addi) → states 0,1,2,3,5,1; `imm_type`=000 in DECODE; `reg_we` and `pc_we` high in WB; `instret`=1.
- Load 0x0000A103 with `mem_ready` low for 2 cycles in MEM → 7 cycles total; `mem_req` continuous through MEM; `wb_sel`=01 in WB.
- Branch 0x00208463, `branch_taken`=1, then again with `branch_taken`=0 → `pc_sel`=01 then 00; `imm_type`=010; 3 cycles each.
- JAL 0x008000EF → `imm_type`=100; EXEC asserts `reg_we`, `pc_we`, `wb_sel`=10 and `pc_sel`=01 together.
- Opcode 0x0000007F → with the macro, TRAP and `illegal` held; without it, a one-cycle `illegal` pulse and FETCH after 3 cycles.
- `rst` asserted during MEM of a store → all outputs 0 immediately; `instret` reads 0.
